// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {BOOT, RUN, PEND, HALT} pc_state_e;

  localparam int INST_BYTES = 4;
  localparam int ALIGN_BITS = 2;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request channel between pc_gen and instruction memory, plus the redirect
// path from pc_add2 and the sticky misaligned-redirect error.
interface pc_gen_if #(parameter int DATAWIDTH = 32);

  logic                 redirect_i;
  logic [DATAWIDTH-1:0] redirect_target_i;
  logic                 if_ready_i;
  logic                 if_valid_o;
  logic [DATAWIDTH-1:0] if_pc_o;
  logic                 err_o;

  modport master (
    input  redirect_i,
    input  redirect_target_i,
    input  if_ready_i,
    output if_valid_o,
    output if_pc_o,
    output err_o
  );

  modport slave (
    output redirect_i,
    output redirect_target_i,
    output if_ready_i,
    input  if_valid_o,
    input  if_pc_o,
    input  err_o
  );

endinterface

// File: rtl/pc_gen_adder.sv
// Plain modulo-2^DATAWIDTH adder, used here as the sequential PC incrementer.
module adder #(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] B,
  output logic [DATAWIDTH-1:0] Result
);

  assign Result = A + B;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: holds the fetch PC, offers it over valid/ready,
// advances on accept and redirects to targets supplied by pc_add2.
module pc_gen
  import pc_pkg::*;
#(
  parameter int                   DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
  input logic        clk,
  input logic        rst,
  pc_gen_if.master   bus
);

  pc_state_e            state_q, state_d;
  logic [DATAWIDTH-1:0] pc_q, pc_d;
  logic [DATAWIDTH-1:0] pend_q, pend_d;
  logic [DATAWIDTH-1:0] pc_inc;
  logic                 valid;
  logic                 accept;
  logic                 misaligned;

  adder #(.DATAWIDTH(DATAWIDTH)) u_inc (
    .A      (pc_q),
    .B      (DATAWIDTH'(INST_BYTES)),
    .Result (pc_inc)
  );

  // Outputs decode registered state only, so nothing from the inputs reaches them.
  assign valid          = (state_q == RUN) || (state_q == PEND);
  assign bus.if_valid_o = valid;
  assign bus.if_pc_o    = pc_q;
  assign bus.err_o      = (state_q == HALT);

  assign accept     = valid & bus.if_ready_i;
  assign misaligned = bus.redirect_i &
                      (bus.redirect_target_i[ALIGN_BITS-1:0] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (misaligned) begin
          state_d = HALT;
        end else if (bus.redirect_i && accept) begin
          pc_d = bus.redirect_target_i;
        end else if (bus.redirect_i) begin
          // Request is outstanding, so the PC must hold; park the target.
          pend_d  = bus.redirect_target_i;
          state_d = PEND;
        end else if (accept) begin
          pc_d = pc_inc;
        end
      end
      PEND: begin
        if (misaligned) begin
          state_d = HALT;
        end else begin
          if (bus.redirect_i) begin
            pend_d = bus.redirect_target_i;
          end
          if (accept) begin
            pc_d    = bus.redirect_i ? bus.redirect_target_i : pend_q;
            state_d = RUN;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

endmodule
